// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Sequencer for one motion-compensation macroblock job. For each
//               of N_DC blocks it loads MB_SIZE current rows, then MB_SIZE
//               reference rows, then emits MB_SIZE residual rows. It then
//               emits N_DC DC-coefficient cycles and pulses done.
// Ports       : clk, reset (sync, active-high)
//               start, abort                   - job control
//               curr_valid, ref_valid          - row supply handshakes
//               residual_ready                 - residual sink handshake
//               load_curr, load_ref, output_residual_row,
//               start_dc_calc, output_dcco     - datapath strobes
//               curr_ack, ref_ack, residual_valid - handshake responses
//               row_idx, dc_count              - row / block counters
//               busy, done                     - status
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller #(
    parameter int MB_SIZE = 4,
    parameter int N_DC    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       curr_valid,
    input  logic       ref_valid,
    input  logic       residual_ready,
    output logic       load_curr,
    output logic       load_ref,
    output logic       output_residual_row,
    output logic       start_dc_calc,
    output logic       output_dcco,
    output logic [3:0] dc_count,
    output logic [3:0] row_idx,
    output logic       curr_ack,
    output logic       ref_ack,
    output logic       residual_valid,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] C_LAST_ROW = 4'(MB_SIZE - 1);
    localparam logic [3:0] C_LAST_DC  = 4'(N_DC - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_CUR = 3'd1,
        ST_LOAD_REF = 3'd2,
        ST_RESID    = 3'd3,
        ST_OUT_DC   = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_row_idx;
    logic [3:0] w_row_nxt;
    logic [3:0] r_dc_count;
    logic [3:0] w_dc_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_row_idx  <= 4'd0;
            r_dc_count <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_row_idx  <= w_row_nxt;
            r_dc_count <= w_dc_nxt;
        end
    end

    // Counters are visible registered values, masked while reset is held so
    // that every output reads zero in a reset cycle.
    assign row_idx  = reset ? 4'd0 : r_row_idx;
    assign dc_count = reset ? 4'd0 : r_dc_count;

    always_comb begin
        w_state_nxt         = r_state;
        w_row_nxt           = r_row_idx;
        w_dc_nxt            = r_dc_count;
        load_curr           = 1'b0;
        load_ref            = 1'b0;
        output_residual_row = 1'b0;
        start_dc_calc       = 1'b0;
        output_dcco         = 1'b0;
        curr_ack            = 1'b0;
        ref_ack             = 1'b0;
        residual_valid      = 1'b0;
        busy                = 1'b0;
        done                = 1'b0;

        if (!reset) begin
            busy = (r_state != ST_IDLE);
            if (abort) begin
                // Abort suppresses every strobe (including done) this cycle.
                w_state_nxt = ST_IDLE;
                w_row_nxt   = 4'd0;
                w_dc_nxt    = 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            w_state_nxt = ST_LOAD_CUR;
                            w_row_nxt   = 4'd0;
                            w_dc_nxt    = 4'd0;
                        end
                    end
                    ST_LOAD_CUR: begin
                        load_curr = curr_valid;
                        curr_ack  = curr_valid;
                        if (curr_valid) begin
                            if (r_row_idx == C_LAST_ROW) begin
                                w_row_nxt   = 4'd0;
                                w_state_nxt = ST_LOAD_REF;
                            end else begin
                                w_row_nxt = r_row_idx + 4'd1;
                            end
                        end
                    end
                    ST_LOAD_REF: begin
                        load_ref = ref_valid;
                        ref_ack  = ref_valid;
                        if (ref_valid) begin
                            if (r_row_idx == C_LAST_ROW) begin
                                w_row_nxt   = 4'd0;
                                w_state_nxt = ST_RESID;
                            end else begin
                                w_row_nxt = r_row_idx + 4'd1;
                            end
                        end
                    end
                    ST_RESID: begin
                        output_residual_row = residual_ready;
                        residual_valid      = residual_ready;
                        if (residual_ready) begin
                            if (r_row_idx == C_LAST_ROW) begin
                                // Last residual row of the block kicks off the
                                // DC calculation and selects the next block.
                                start_dc_calc = 1'b1;
                                w_row_nxt     = 4'd0;
                                if (r_dc_count < C_LAST_DC) begin
                                    w_dc_nxt    = r_dc_count + 4'd1;
                                    w_state_nxt = ST_LOAD_CUR;
                                end else begin
                                    w_dc_nxt    = 4'd0;
                                    w_state_nxt = ST_OUT_DC;
                                end
                            end else begin
                                w_row_nxt = r_row_idx + 4'd1;
                            end
                        end
                    end
                    ST_OUT_DC: begin
                        // row_idx doubles as the DC output counter here.
                        output_dcco = 1'b1;
                        if (r_row_idx == C_LAST_DC) begin
                            w_row_nxt   = 4'd0;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_row_nxt = r_row_idx + 4'd1;
                        end
                    end
                    ST_DONE: begin
                        done        = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_row_nxt   = 4'd0;
                        w_dc_nxt    = 4'd0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Self-checking bench for mc_controller. A queue-of-beats model
//               expands each accepted job into its expected sequence of row,
//               DC and done beats and is compared with the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

    localparam int MB = 4;
    localparam int ND = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       curr_valid = 1'b0;
    logic       ref_valid = 1'b0;
    logic       residual_ready = 1'b0;
    logic       load_curr, load_ref, output_residual_row, start_dc_calc, output_dcco;
    logic [3:0] dc_count, row_idx;
    logic       curr_ack, ref_ack, residual_valid, busy, done;

    always #5 clk = ~clk;

    mc_controller #(.MB_SIZE(MB), .N_DC(ND)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .abort               (abort),
        .curr_valid          (curr_valid),
        .ref_valid           (ref_valid),
        .residual_ready      (residual_ready),
        .load_curr           (load_curr),
        .load_ref            (load_ref),
        .output_residual_row (output_residual_row),
        .start_dc_calc       (start_dc_calc),
        .output_dcco         (output_dcco),
        .dc_count            (dc_count),
        .row_idx             (row_idx),
        .curr_ack            (curr_ack),
        .ref_ack             (ref_ack),
        .residual_valid      (residual_valid),
        .busy                (busy),
        .done                (done)
    );

    // Beat kinds: 0 current row, 1 reference row, 2 residual row, 3 DC, 4 done
    typedef struct packed {
        logic [2:0] kind;
        logic [3:0] row;
        logic [3:0] blk;
    } item_t;

    item_t      q[$];
    int         errors = 0;
    int         checks = 0;
    int         job_cyc = -1;
    int         last_lat = 0;
    int         n_lc, n_lr, n_res, n_dcc, n_sdc;
    bit         done_seen = 1'b0;
    int         sdc_dc[$];
    int         cyc = 0;

    item_t      h;
    bit         pop;
    logic [17:0] e_vec, a_vec;
    logic       e_lc, e_lr, e_orr, e_sdc, e_dcc, e_cack, e_rack, e_rv, e_busy, e_done;
    logic [3:0] e_row, e_dc;

    task automatic push_job();
        for (int b = 0; b < ND; b++)
            for (int k = 0; k < 3; k++)
                for (int r = 0; r < MB; r++)
                    q.push_back('{kind: 3'(k), row: 4'(r), blk: 4'(b)});
        for (int r = 0; r < ND; r++)
            q.push_back('{kind: 3'd3, row: 4'(r), blk: 4'd0});
        q.push_back('{kind: 3'd4, row: 4'd0, blk: 4'd0});
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound, input string name);
        int i;
        for (i = 0; i < bound; i++) begin
            if (done_seen) break;
            tick();
        end
        if (!done_seen) chk({name, "_timeout"}, 0, 1);
    endtask

    // Reference model and per-cycle comparison, evaluated mid-cycle.
    always @(negedge clk) begin
        cyc++;
        e_lc = 0; e_lr = 0; e_orr = 0; e_sdc = 0; e_dcc = 0;
        e_cack = 0; e_rack = 0; e_rv = 0; e_busy = 0; e_done = 0;
        e_row = 0; e_dc = 0; pop = 0;
        if (job_cyc >= 0) job_cyc++;
        if (reset) begin
            q.delete();
        end else begin
            e_busy = (q.size() != 0);
            if (q.size() != 0) begin
                h = q[0];
                e_row = h.row;
                e_dc  = h.blk;
            end
            if (abort) begin
                q.delete();
            end else if (q.size() == 0) begin
                if (start) begin
                    push_job();
                    job_cyc = 0;
                    n_lc = 0; n_lr = 0; n_res = 0; n_dcc = 0; n_sdc = 0;
                    sdc_dc.delete();
                    done_seen = 1'b0;
                end
            end else begin
                case (h.kind)
                    3'd0: begin e_lc = curr_valid; e_cack = curr_valid; pop = curr_valid; end
                    3'd1: begin e_lr = ref_valid; e_rack = ref_valid; pop = ref_valid; end
                    3'd2: begin
                        e_orr = residual_ready; e_rv = residual_ready;
                        e_sdc = residual_ready && (h.row == 4'(MB - 1));
                        pop = residual_ready;
                    end
                    3'd3: begin e_dcc = 1; pop = 1; end
                    default: begin e_done = 1; pop = 1; end
                endcase
                if (pop) void'(q.pop_front());
            end
        end

        e_vec = {e_lc, e_lr, e_orr, e_sdc, e_dcc, e_cack, e_rack, e_rv, e_busy, e_done, e_row, e_dc};
        a_vec = {load_curr, load_ref, output_residual_row, start_dc_calc, output_dcco,
                 curr_ack, ref_ack, residual_valid, busy, done, row_idx, dc_count};
        checks++;
        if (a_vec !== e_vec) begin
            errors++;
            $display("FAIL cycle %0d outputs {lc,lr,orr,sdc,dcc,cack,rack,rv,busy,done,row,dc}: got %b expected %b",
                     cyc, a_vec, e_vec);
        end
        checks++;
        if ($countones({load_curr, load_ref, output_residual_row, output_dcco}) > 1) begin
            errors++;
            $display("FAIL cycle %0d exclusive strobes: got %b expected at most one set", cyc,
                     {load_curr, load_ref, output_residual_row, output_dcco});
        end

        n_lc  += int'(load_curr);
        n_lr  += int'(load_ref);
        n_res += int'(output_residual_row);
        n_dcc += int'(output_dcco);
        if (start_dc_calc) begin
            n_sdc++;
            sdc_dc.push_back(int'(dc_count));
        end
        if (done === 1'b1) begin
            done_seen = 1'b1;
            last_lat  = job_cyc;
        end
    end

    initial begin
        int k;
        // Pin the model's job expansion to hand-computed values.
        push_job();
        chk("model_len", q.size(), 53);
        chk("model_first_res", int'(q[8].kind), 2);
        chk("model_last_block_res", int'(q[47].blk), 3);
        chk("model_done_item", int'(q[52].kind), 4);
        q.delete();

        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick();
        chk("rst_row", int'(row_idx), 0);
        chk("rst_dc", int'(dc_count), 0);
        repeat (3) tick();
        chk("idle_no_start", int'(busy), 0);

        // Nominal job with all handshakes high.
        curr_valid = 1; ref_valid = 1; residual_ready = 1;
        start = 1; tick(); start = 0;
        wait_done(200, "nom");
        chk("nom_latency", last_lat, 53);
        chk("nom_load_curr", n_lc, 16);
        chk("nom_load_ref", n_lr, 16);
        chk("nom_resid", n_res, 16);
        chk("nom_dcco", n_dcc, 4);
        chk("nom_sdc", n_sdc, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("nom_sdc_dc%0d", i), (i < sdc_dc.size()) ? sdc_dc[i] : -1, i);
        tick(); tick();

        // Stalls: curr_valid low 3 cycles in LOAD_CUR, residual_ready low 2 in RESID.
        start = 1; tick(); start = 0;
        for (k = 1; k < 200 && !done_seen; k++) begin
            curr_valid     = !(k >= 3 && k <= 5);
            residual_ready = !(k == 13 || k == 14);
            tick();
        end
        curr_valid = 1; residual_ready = 1;
        chk("stall_done", int'(done_seen), 1);
        chk("stall_latency", last_lat, 58);
        tick(); tick();

        // Abort during block 2 residual phase.
        start = 1; tick(); start = 0;
        for (k = 1; k <= 34; k++) begin
            abort = (k == 34);
            tick();
        end
        abort = 0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_dc", int'(dc_count), 0);
        chk("abort_row", int'(row_idx), 0);
        repeat (60) tick();
        chk("abort_no_done", int'(done_seen), 0);
        start = 1; tick(); start = 0;
        wait_done(200, "post_abort");
        chk("post_abort_latency", last_lat, 53);
        tick(); tick();

        // Reset during OUT_DC after the second DC output.
        start = 1; tick(); start = 0;
        for (k = 1; k <= 50; k++) tick();
        reset = 1; start = 1;
        tick();
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_dcco", int'(output_dcco), 0);
        tick();
        reset = 0; start = 0;
        repeat (8) tick();
        chk("rst_mid_dcco_count", n_dcc, 2);
        chk("rst_mid_idle", int'(busy), 0);
        chk("rst_mid_no_done", int'(done_seen), 0);

        // Randomized handshakes, start pulses (also while busy), rare abort/reset.
        for (int i = 0; i < 4000; i++) begin
            curr_valid     = ($urandom_range(0, 3) != 0);
            ref_valid      = ($urandom_range(0, 3) != 0);
            residual_ready = ($urandom_range(0, 3) != 0);
            start          = ($urandom_range(0, 9) == 0);
            abort          = ($urandom_range(0, 299) == 0);
            reset          = ($urandom_range(0, 599) == 0);
            tick();
        end
        start = 0; abort = 0; reset = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
